// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage between the ID/EX and EX/MEM latches.
// It forwards operands from EX/MEM and MEM/WB, runs the ALU and registers
// the result, store data, destination and controls into EX/MEM.
// Optional feature macro: EX_MULT_EN builds the iterative shift-add
// multiplier (funct 0x18) together with its upstream stall. Without it,
// funct 0x18 behaves as an unknown funct: result 0, latency 1, no stall.
module ex_stage #(
    parameter int W       = 32,
    parameter int MUL_CYC = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic [4:0]   i_rs,
    input  logic [4:0]   i_rt,
    input  logic [4:0]   i_rd,
    input  logic         i_regdst,
    input  logic         i_memread,
    input  logic         i_memtoreg,
    input  logic         i_memwrite,
    input  logic         i_alusrc,
    input  logic         i_regwrite,
    input  logic [1:0]   i_aluop,
    input  logic [W-1:0] i_immediate,
    input  logic [W-1:0] i_read1,
    input  logic [W-1:0] i_read2,
    input  logic         i_wb_regwrite,
    input  logic [4:0]   i_wb_rd,
    input  logic [W-1:0] i_wb_data,
    output logic [W-1:0] o_alu_out,
    output logic [W-1:0] o_wdata_out,
    output logic [4:0]   o_dst_out,
    output logic         o_memreadout,
    output logic         o_memtoregout,
    output logic         o_memwriteout,
    output logic         o_regwriteout,
    output logic         o_zero_out,
    output logic         o_stall
);

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // EX/MEM latch
    logic [W-1:0] r_alu_out;
    logic [W-1:0] r_wdata_out;
    logic [4:0]   r_dst_out;
    logic         r_memreadout;
    logic         r_memtoregout;
    logic         r_memwriteout;
    logic         r_regwriteout;
    logic         r_zero_out;

    logic [W-1:0] w_fwd_a;
    logic [W-1:0] w_fwd_b;
    logic [W-1:0] w_alu_b;
    logic [W-1:0] w_alu_res;
    logic [W-1:0] w_result;
    logic [5:0]   w_funct;
    logic         w_stall;
    logic         w_load;

    assign w_funct = i_immediate[5:0];

    // Operand A forwarding: the younger EX/MEM result beats MEM/WB; $0 never forwards
    always_comb begin
        w_fwd_a = i_read1;
        if (r_regwriteout && (r_dst_out != 5'd0) && (r_dst_out == i_rs)) begin
            w_fwd_a = r_alu_out;
        end else if (i_wb_regwrite && (i_wb_rd != 5'd0) && (i_wb_rd == i_rs)) begin
            w_fwd_a = i_wb_data;
        end else begin
            w_fwd_a = i_read1;
        end
    end

    // Operand B forwarding, same priority as operand A
    always_comb begin
        w_fwd_b = i_read2;
        if (r_regwriteout && (r_dst_out != 5'd0) && (r_dst_out == i_rt)) begin
            w_fwd_b = r_alu_out;
        end else if (i_wb_regwrite && (i_wb_rd != 5'd0) && (i_wb_rd == i_rt)) begin
            w_fwd_b = i_wb_data;
        end else begin
            w_fwd_b = i_read2;
        end
    end

    assign w_alu_b = i_alusrc ? i_immediate : w_fwd_b;

    // Single-cycle ALU; mult and unknown functs produce 0 here
    always_comb begin
        w_alu_res = {W{1'b0}};
        case (i_aluop)
            2'b00: w_alu_res = w_fwd_a + w_alu_b;
            2'b01: w_alu_res = w_fwd_a - w_alu_b;
            2'b10: begin
                case (w_funct)
                    FN_ADD: w_alu_res = w_fwd_a + w_alu_b;
                    FN_SUB: w_alu_res = w_fwd_a - w_alu_b;
                    FN_AND: w_alu_res = w_fwd_a & w_alu_b;
                    FN_OR:  w_alu_res = w_fwd_a | w_alu_b;
                    FN_SLT: begin
                        if ($signed(w_fwd_a) < $signed(w_alu_b)) begin
                            w_alu_res = {{(W-1){1'b0}}, 1'b1};
                        end else begin
                            w_alu_res = {W{1'b0}};
                        end
                    end
                    default: w_alu_res = {W{1'b0}};
                endcase
            end
            2'b11: w_alu_res = w_fwd_a | w_alu_b;
            default: w_alu_res = {W{1'b0}};
        endcase
    end

`ifdef EX_MULT_EN
    localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
    localparam logic [5:0] FN_MUL = 6'h18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    mul_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0] r_mcand;
    logic [W-1:0] r_mplier;
    logic [W-1:0] r_prod;
    logic         w_mul_dec;
    logic         w_mul_done;

    assign w_mul_dec = (i_aluop == 2'b10) && (w_funct == FN_MUL);

    // Stall while a multiply is starting or iterating; flush releases it at once
    always_comb begin
        w_stall    = 1'b0;
        w_mul_done = 1'b0;
        case (r_state)
            ST_IDLE: w_stall    = w_mul_dec && !i_flush;
            ST_BUSY: w_stall    = !i_flush;
            ST_DONE: w_mul_done = !i_flush;
            default: w_stall    = 1'b0;
        endcase
    end

    // Multiplier FSM: latch forwarded operands, one shift-add per BUSY cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_mcand  <= {W{1'b0}};
            r_mplier <= {W{1'b0}};
            r_prod   <= {W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mul_dec && !i_flush) begin
                        r_state  <= ST_BUSY;
                        r_cnt    <= {CW{1'b0}};
                        r_mcand  <= w_fwd_a;
                        r_mplier <= w_fwd_b;
                        r_prod   <= {W{1'b0}};
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (i_flush) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= {CW{1'b0}};
                    end else begin
                        if (r_mplier[0]) begin
                            r_prod <= r_prod + r_mcand;
                        end else begin
                            r_prod <= r_prod;
                        end
                        r_mcand  <= {r_mcand[W-2:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[W-1:1]};
                        if (r_cnt == CW'(MUL_CYC - 1)) begin
                            r_state <= ST_DONE;
                            r_cnt   <= {CW{1'b0}};
                        end else begin
                            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign w_result = w_mul_done ? r_prod : w_alu_res;
`else
    assign w_stall  = 1'b0;
    assign w_result = w_alu_res;
`endif

    assign w_load = !w_stall && !i_flush;

    // EX/MEM latch: load on a normal cycle, otherwise insert a bubble holding data
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_alu_out     <= {W{1'b0}};
            r_wdata_out   <= {W{1'b0}};
            r_dst_out     <= 5'd0;
            r_memreadout  <= 1'b0;
            r_memtoregout <= 1'b0;
            r_memwriteout <= 1'b0;
            r_regwriteout <= 1'b0;
            r_zero_out    <= 1'b0;
        end else if (w_load) begin
            r_alu_out     <= w_result;
            r_wdata_out   <= w_fwd_b;
            r_dst_out     <= i_regdst ? i_rd : i_rt;
            r_memreadout  <= i_memread;
            r_memtoregout <= i_memtoreg;
            r_memwriteout <= i_memwrite;
            r_regwriteout <= i_regwrite;
            r_zero_out    <= (w_result == {W{1'b0}});
        end else begin
            r_memreadout  <= 1'b0;
            r_memtoregout <= 1'b0;
            r_memwriteout <= 1'b0;
            r_regwriteout <= 1'b0;
        end
    end

    assign o_alu_out     = r_alu_out;
    assign o_wdata_out   = r_wdata_out;
    assign o_dst_out     = r_dst_out;
    assign o_memreadout  = r_memreadout;
    assign o_memtoregout = r_memtoregout;
    assign o_memwriteout = r_memwriteout;
    assign o_regwriteout = r_regwriteout;
    assign o_zero_out    = r_zero_out;
    assign o_stall       = w_stall;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage. Multiplier scenarios are compiled only
// when EX_MULT_EN is defined; otherwise funct 0x18 is checked to yield 0.
module tb_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [4:0]  rs, rt, rd;
    logic        regdst, memread, memtoreg, memwrite, alusrc, regwrite;
    logic [1:0]  aluop;
    logic [31:0] imm, read1, read2;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] alu_out, wdata_out;
    logic [4:0]  dst_out;
    logic        memreadout, memtoregout, memwriteout, regwriteout, zero_out, stall;

    int errors = 0;
    int checks = 0;

    ex_stage #(.W(32), .MUL_CYC(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_rs(rs), .i_rt(rt), .i_rd(rd),
        .i_regdst(regdst), .i_memread(memread), .i_memtoreg(memtoreg),
        .i_memwrite(memwrite), .i_alusrc(alusrc), .i_regwrite(regwrite),
        .i_aluop(aluop), .i_immediate(imm), .i_read1(read1), .i_read2(read2),
        .i_wb_regwrite(wb_regwrite), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_alu_out(alu_out), .o_wdata_out(wdata_out), .o_dst_out(dst_out),
        .o_memreadout(memreadout), .o_memtoregout(memtoregout),
        .o_memwriteout(memwriteout), .o_regwriteout(regwriteout),
        .o_zero_out(zero_out), .o_stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [31:0] im,
                          input logic [4:0] a_rs, input logic [4:0] a_rt, input logic [4:0] a_rd,
                          input logic dsel, input logic src, input logic wr,
                          input logic [31:0] r1, input logic [31:0] r2);
        aluop = op; imm = im; rs = a_rs; rt = a_rt; rd = a_rd;
        regdst = dsel; alusrc = src; regwrite = wr; read1 = r1; read2 = r2;
        memread = 1'b0; memtoreg = 1'b0; memwrite = 1'b0;
    endtask

    task automatic set_nop();
        set_op(2'b00, 32'd0, 5'd25, 5'd26, 5'd27, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        set_op(2'b10, 32'h20, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7);
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (alu_out !== 32'd12) begin errors++; $display("FAIL pre_reset_load alu_out=%h expected=%h", alu_out, 32'd12); end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({alu_out, wdata_out, dst_out, memreadout, memtoregout, memwriteout, regwriteout, zero_out} !== 75'd0) begin
            errors++; $display("FAIL reset_outputs alu=%h wdata=%h dst=%0d ctl=%b%b%b%b zero=%b expected all 0",
                               alu_out, wdata_out, dst_out, memreadout, memtoregout, memwriteout, regwriteout, zero_out);
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall stall=%b expected=0", stall); end
        rst_n = 1'b1;
    endtask

    task automatic test_forwarding();
        set_op(2'b10, 32'h20, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7);
        tick();
        checks++; if (alu_out !== 32'd12) begin errors++; $display("FAIL fwd_first alu_out=%0d expected=12", alu_out); end
        checks++; if (dst_out !== 5'd3 || regwriteout !== 1'b1) begin errors++; $display("FAIL fwd_first_dst dst=%0d rw=%b expected 3/1", dst_out, regwriteout); end
        set_op(2'b10, 32'h20, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 32'd99, 32'd99);
        tick();
        checks++; if (alu_out !== 32'd24) begin errors++; $display("FAIL fwd_exmem alu_out=%0d expected=24", alu_out); end
        checks++; if (wdata_out !== 32'd12) begin errors++; $display("FAIL fwd_wdata wdata_out=%0d expected=12", wdata_out); end
        wb_regwrite = 1'b1; wb_rd = 5'd4; wb_data = 32'd1000;
        set_op(2'b10, 32'h20, 5'd4, 5'd4, 5'd5, 1'b1, 1'b0, 1'b1, 32'd55, 32'd55);
        tick();
        checks++; if (alu_out !== 32'd48) begin errors++; $display("FAIL fwd_priority alu_out=%0d expected=48", alu_out); end
        wb_rd = 5'd6; wb_data = 32'd100;
        set_op(2'b10, 32'h20, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0, 1'b1, 32'd1, 32'd2);
        tick();
        checks++; if (alu_out !== 32'd102) begin errors++; $display("FAIL fwd_memwb alu_out=%0d expected=102", alu_out); end
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        set_op(2'b10, 32'h20, 5'd10, 5'd11, 5'd0, 1'b1, 1'b0, 1'b1, 32'd70, 32'd7);
        tick();
        checks++; if (alu_out !== 32'd77 || dst_out !== 5'd0 || regwriteout !== 1'b1) begin
            errors++; $display("FAIL rd0_setup alu=%0d dst=%0d rw=%b expected 77/0/1", alu_out, dst_out, regwriteout); end
        set_op(2'b10, 32'h20, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 32'd9, 32'd0);
        tick();
        checks++; if (alu_out !== 32'd9) begin errors++; $display("FAIL rd0_no_forward alu_out=%0d expected=9", alu_out); end
    endtask

    task automatic test_alu_ops();
        logic [1:0]  t_op  [9] = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10};
        logic [31:0] t_imm [9] = '{32'd3, 32'h0F, 32'h24, 32'h25, 32'h2A, 32'h2A, 32'h22, 32'd2, 32'h3F};
        logic        t_src [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] t_a   [9] = '{32'd10, 32'hF0, 32'hFF00FF00, 32'h12, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd5};
        logic [31:0] t_b   [9] = '{32'd0, 32'd0, 32'h0FF00FF0, 32'h21, 32'd1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd3};
        logic [31:0] t_exp [9] = '{32'd7, 32'hFF, 32'h0F000F00, 32'h33, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0};
        for (int i = 0; i < 9; i++) begin
            set_op(t_op[i], t_imm[i], 5'd20, 5'd21, 5'd22, 1'b1, t_src[i], 1'b0, t_a[i], t_b[i]);
            tick();
            checks++; if (alu_out !== t_exp[i]) begin errors++; $display("FAIL alu_op[%0d] alu_out=%h expected=%h", i, alu_out, t_exp[i]); end
            checks++; if (zero_out !== (t_exp[i] == 32'd0)) begin errors++; $display("FAIL alu_zero[%0d] zero_out=%b expected=%b", i, zero_out, (t_exp[i] == 32'd0)); end
        end
    endtask

    task automatic test_controls_bubble();
        set_op(2'b10, 32'h20, 5'd20, 5'd21, 5'd22, 1'b0, 1'b0, 1'b1, 32'd1, 32'd2);
        memread = 1'b1; memtoreg = 1'b1; memwrite = 1'b1;
        tick();
        checks++; if (alu_out !== 32'd3 || dst_out !== 5'd21) begin errors++; $display("FAIL ctl_load alu=%0d dst=%0d expected 3/21", alu_out, dst_out); end
        checks++; if ({memreadout, memtoregout, memwriteout, regwriteout} !== 4'b1111) begin
            errors++; $display("FAIL ctl_pass ctl=%b%b%b%b expected 1111", memreadout, memtoregout, memwriteout, regwriteout); end
        flush = 1'b1;
        set_op(2'b10, 32'h20, 5'd20, 5'd21, 5'd22, 1'b1, 1'b0, 1'b1, 32'd40, 32'd2);
        memread = 1'b1; memtoreg = 1'b1; memwrite = 1'b1;
        tick();
        checks++; if ({memreadout, memtoregout, memwriteout, regwriteout} !== 4'b0000) begin
            errors++; $display("FAIL flush_bubble ctl=%b%b%b%b expected 0000", memreadout, memtoregout, memwriteout, regwriteout); end
        checks++; if (alu_out !== 32'd3 || dst_out !== 5'd21) begin errors++; $display("FAIL flush_hold alu=%0d dst=%0d expected 3/21", alu_out, dst_out); end
        flush = 1'b0;
        set_nop();
        tick();
    endtask

`ifndef EX_MULT_EN
    task automatic test_mult_disabled();
        set_op(2'b10, 32'h18, 5'd13, 5'd14, 5'd15, 1'b1, 1'b0, 1'b1, 32'd7, 32'd6);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nomul_stall stall=%b expected=0", stall); end
        tick();
        checks++; if (alu_out !== 32'd0 || zero_out !== 1'b1) begin errors++; $display("FAIL nomul_result alu=%h zero=%b expected 0/1", alu_out, zero_out); end
        checks++; if (regwriteout !== 1'b1 || dst_out !== 5'd15) begin errors++; $display("FAIL nomul_ctl rw=%b dst=%0d expected 1/15", regwriteout, dst_out); end
        set_nop();
        tick();
    endtask
`else
    task automatic test_multiply();
        int n;
        logic bubble_bad;
        set_nop();
        tick();
        set_op(2'b10, 32'h18, 5'd13, 5'd14, 5'd15, 1'b1, 1'b0, 1'b1, 32'd7, 32'd6);
        #1;
        n = 0; bubble_bad = 1'b0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            if (n == 5) begin wb_regwrite = 1'b1; wb_rd = 5'd13; wb_data = 32'd100; end
            if (regwriteout !== 1'b0) bubble_bad = 1'b1;
            tick();
        end
        checks++; if (n != 33) begin errors++; $display("FAIL mul_stall_cycles got=%0d expected=33", n); end
        checks++; if (bubble_bad !== 1'b0) begin errors++; $display("FAIL mul_bubble regwriteout seen=%b expected=0", bubble_bad); end
        tick();
        checks++; if (alu_out !== 32'd42) begin errors++; $display("FAIL mul_result alu_out=%0d expected=42", alu_out); end
        checks++; if (regwriteout !== 1'b1 || dst_out !== 5'd15 || zero_out !== 1'b0) begin
            errors++; $display("FAIL mul_ctl rw=%b dst=%0d zero=%b expected 1/15/0", regwriteout, dst_out, zero_out); end
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        set_nop();
        tick();
    endtask

    task automatic test_mult_abort();
        // flush at BUSY cycle 10
        set_op(2'b10, 32'h18, 5'd13, 5'd14, 5'd15, 1'b1, 1'b0, 1'b1, 32'd7, 32'd6);
        for (int i = 0; i < 11; i++) tick();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL abort_busy stall=%b expected=1", stall); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_nop();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL abort_flush_stall stall=%b expected=0", stall); end
        checks++; if ({memreadout, memtoregout, memwriteout, regwriteout} !== 4'b0000 || alu_out !== 32'd2) begin
            errors++; $display("FAIL abort_flush_out alu=%0d ctl=%b%b%b%b expected 2/0000", alu_out, memreadout, memtoregout, memwriteout, regwriteout); end
        tick();
        // reset at BUSY cycle 10
        set_op(2'b10, 32'h18, 5'd13, 5'd14, 5'd15, 1'b1, 1'b0, 1'b1, 32'd7, 32'd6);
        for (int i = 0; i < 11; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_nop();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL abort_reset_stall stall=%b expected=0", stall); end
        checks++;
        if ({alu_out, wdata_out, dst_out, memreadout, memtoregout, memwriteout, regwriteout, zero_out} !== 75'd0) begin
            errors++; $display("FAIL abort_reset_out alu=%h wdata=%h dst=%0d ctl=%b%b%b%b zero=%b expected all 0",
                               alu_out, wdata_out, dst_out, memreadout, memtoregout, memwriteout, regwriteout, zero_out);
        end
        tick();
        // flush together with mult decode in IDLE: no start
        set_op(2'b10, 32'h18, 5'd13, 5'd14, 5'd15, 1'b1, 1'b0, 1'b1, 32'd7, 32'd6);
        flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_start_stall stall=%b expected=0", stall); end
        tick();
        flush = 1'b0;
        set_nop();
        #1;
        checks++; if (stall !== 1'b0 || regwriteout !== 1'b0) begin errors++; $display("FAIL flush_start_idle stall=%b rw=%b expected 0/0", stall, regwriteout); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_forwarding();
        test_alu_ops();
        test_controls_bubble();
`ifdef EX_MULT_EN
        test_multiply();
        test_mult_abort();
`else
        test_mult_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
